// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider among NUM_REQ requesters, with flush and watchdog.
// Optional DIV_ZERO_BYPASS_EN: divide-by-zero requests are answered locally without using the divider.
module div_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int WATCHDOG = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [3*NUM_REQ-1:0]   req_funct3_i,
  input  logic [32*NUM_REQ-1:0]  req_rs1_i,
  input  logic [32*NUM_REQ-1:0]  req_rs2_i,
  input  logic [5*NUM_REQ-1:0]   req_rd_i,
  input  logic [NUM_REQ-1:0]     flush_i,
  output logic [NUM_REQ-1:0]     resp_valid_o,
  output logic [4:0]             resp_rd_o,
  output logic [31:0]            resp_result_o,
  output logic                   resp_err_o,
  output logic                   busy_o,
  output logic                   div_start_o,
  output logic                   div_valid_o,
  output logic                   div_flush_o,
  output logic [2:0]             div_funct3_o,
  output logic [31:0]            div_rs1_o,
  output logic [31:0]            div_rs2_o,
  output logic [4:0]             div_rd_o,
  input  logic                   div_ready_i,
  input  logic                   div_busy_i,
  input  logic [4:0]             div_rd_i,
  input  logic [31:0]            div_result_i
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W = $clog2(WATCHDOG);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic [RR_W-1:0]   owner_q, owner_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       rs1_q, rs1_d;
  logic [31:0]       rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [31:0]       res_q, res_d;
  logic [4:0]        res_rd_q, res_rd_d;
  logic              err_q, err_d;

  logic              grant_found;
  logic [RR_W-1:0]   grant_idx;
  logic              grant;
  logic              owner_flush;
  logic              wd_hit;

  // Rotating priority: search upward from rr_q with wrap, skipping flushed requesters.
  always_comb begin : arb_c
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid_i[idx] && !flush_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = RR_W'(idx);
      end
    end
  end

  assign grant       = grant_found && !div_busy_i && (state_q == ST_IDLE) && !reset;
  assign owner_flush = flush_i[owner_q];
  assign wd_hit      = (wd_q == WD_W'(WATCHDOG - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      funct3_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      wd_q     <= '0;
      res_q    <= '0;
      res_rd_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      funct3_q <= funct3_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
      res_q    <= res_d;
      res_rd_q <= res_rd_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    funct3_d = funct3_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    wd_d     = wd_q;
    res_d    = res_q;
    res_rd_d = res_rd_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d  = grant_idx;
          funct3_d = req_funct3_i[int'(grant_idx)*3 +: 3];
          rs1_d    = req_rs1_i[int'(grant_idx)*32 +: 32];
          rs2_d    = req_rs2_i[int'(grant_idx)*32 +: 32];
          rd_d     = req_rd_i[int'(grant_idx)*5 +: 5];
          rr_d     = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
          wd_d     = '0;
          state_d  = ST_ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
          if (req_rs2_i[int'(grant_idx)*32 +: 32] == 32'd0) begin
            // funct3[1] set means REM/REMU: remainder by zero returns the dividend.
            res_d    = req_funct3_i[int'(grant_idx)*3 + 1] ? req_rs1_i[int'(grant_idx)*32 +: 32]
                                                            : 32'hFFFF_FFFF;
            res_rd_d = req_rd_i[int'(grant_idx)*5 +: 5];
            err_d    = 1'b0;
            state_d  = ST_RESP;
          end
`endif
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = owner_flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (owner_flush) begin
          state_d = ST_IDLE;
        end else if (div_ready_i) begin
          res_d    = div_result_i;
          res_rd_d = div_rd_i;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (wd_hit) begin
          res_d    = 32'd0;
          res_rd_d = rd_q;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    if (grant) req_ready_o[grant_idx] = 1'b1;
    if ((state_q == ST_RESP) && !owner_flush && !reset) resp_valid_o[owner_q] = 1'b1;
    busy_o        = (state_q != ST_IDLE);
    div_start_o   = (state_q == ST_ISSUE) && !owner_flush && !reset;
    div_valid_o   = div_start_o;
    div_flush_o   = (state_q == ST_WAIT) && !reset &&
                    (owner_flush || (!div_ready_i && wd_hit));
    div_funct3_o  = funct3_q;
    div_rs1_o     = rs1_q;
    div_rs2_o     = rs2_q;
    div_rd_o      = rd_q;
    resp_rd_o     = res_rd_q;
    resp_result_o = res_q;
    resp_err_o    = err_q;
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized scoreboard bench for div_arbiter: timeline reference model, stub divider, response monitor.
module tb_div_arbiter;
  localparam int N  = 2;
  localparam int WD = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [3*N-1:0]    req_funct3_i = '0;
  logic [32*N-1:0]   req_rs1_i = '0;
  logic [32*N-1:0]   req_rs2_i = '0;
  logic [5*N-1:0]    req_rd_i = '0;
  logic [N-1:0]      flush_i = '0;
  logic [N-1:0]      resp_valid_o;
  logic [4:0]        resp_rd_o;
  logic [31:0]       resp_result_o;
  logic              resp_err_o;
  logic              busy_o;
  logic              div_start_o, div_valid_o, div_flush_o;
  logic [2:0]        div_funct3_o;
  logic [31:0]       div_rs1_o, div_rs2_o;
  logic [4:0]        div_rd_o;
  logic              div_ready_i = 1'b0;
  logic              div_busy_i = 1'b0;
  logic [4:0]        div_rd_i = '0;
  logic [31:0]       div_result_i = '0;

  div_arbiter #(.NUM_REQ(N), .WATCHDOG(WD)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_funct3_i(req_funct3_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .req_rd_i(req_rd_i), .flush_i(flush_i),
    .resp_valid_o(resp_valid_o), .resp_rd_o(resp_rd_o), .resp_result_o(resp_result_o),
    .resp_err_o(resp_err_o), .busy_o(busy_o),
    .div_start_o(div_start_o), .div_valid_o(div_valid_o), .div_flush_o(div_flush_o),
    .div_funct3_o(div_funct3_o), .div_rs1_o(div_rs1_o), .div_rs2_o(div_rs2_o),
    .div_rd_o(div_rd_o), .div_ready_i(div_ready_i), .div_busy_i(div_busy_i),
    .div_rd_i(div_rd_i), .div_result_i(div_result_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic rst_drv = 1'b1;
  logic quiet = 1'b1;

  logic        pend_v[N];
  logic [2:0]  pend_f3[N];
  logic [31:0] pend_a[N];
  logic [31:0] pend_b[N];
  logic [4:0]  pend_rd[N];

  // timeline model: cycle numbers at which each visible event is due
  int rr_m = 0, owner_m = 0;
  int idle_at = 0, start_at = -1, flush_at = -1, fl_own_at = -1;
  logic [2:0]  acc_f3;
  logic [31:0] acc_a, acc_b;
  logic [4:0]  acc_rd;
  int dir_mode = -1, dir_lat = 1, dir_k = 0;

  // stub divider
  logic        st_act = 1'b0;
  int          st_cnt = 0;
  int          st_lat = 1;
  logic        st_hang = 1'b0;
  logic [31:0] st_res = '0;
  logic [4:0]  st_rd = '0;

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    pend_v[i] = 1'b1; pend_f3[i] = f3; pend_a[i] = a; pend_b[i] = b; pend_rd[i] = rd;
  endtask

  task automatic gen_req(input int i);
    int r;
    logic [31:0] a, b;
    r = $urandom_range(0, 19);
    a = $urandom;
    if (r == 0)      b = 32'd0;
    else if (r == 1) begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
    else if (r < 8)  b = 32'($urandom_range(1, 100));
    else             b = $urandom;
    set_req(i, 3'd4 + 3'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)));
  endtask

  task automatic push_exp(input int T);
    exp_t e;
    e.owner = owner_m; e.rd = acc_rd; e.result = ref_div(acc_f3, acc_a, acc_b);
    e.err = 1'b0; e.cyc = T;
    sb_q.push_back(e);
  endtask

  task automatic accept(input int w);
    int md, lat, k, r, T;
    exp_t e;
    T = cyc;
    rr_m = (w + 1) % N;
    owner_m = w;
    acc_f3 = pend_f3[w]; acc_a = pend_a[w]; acc_b = pend_b[w]; acc_rd = pend_rd[w];
    pend_v[w] = 1'b0;
    if (dir_mode >= 0) begin
      md = dir_mode; lat = dir_lat; k = dir_k; dir_mode = -1;
    end else begin
      lat = $urandom_range(1, 6);
      r   = $urandom_range(0, 99);
      md  = (r < 2) ? 4 : (r < 10) ? 1 : (r < 18) ? 2 : (r < 26) ? 3 : 0;
      k   = $urandom_range(0, lat - 1);
    end
    start_at = -1; flush_at = -1; fl_own_at = -1;
`ifdef DIV_ZERO_BYPASS_EN
    if (acc_b == 32'd0) begin
      if (md == 3) fl_own_at = T + 1;
      else push_exp(T + 1);
      idle_at = T + 2;
      return;
    end
`endif
    st_lat = lat;
    st_hang = (md == 4);
    case (md)
      1: begin fl_own_at = T + 1; idle_at = T + 2; end
      2: begin start_at = T + 1; fl_own_at = T + 2 + k; flush_at = T + 2 + k; idle_at = T + 3 + k; end
      3: begin start_at = T + 1; fl_own_at = T + 2 + lat; idle_at = T + 3 + lat; end
      4: begin
        start_at = T + 1; flush_at = T + 1 + WD; idle_at = T + 3 + WD;
        e.owner = owner_m; e.rd = acc_rd; e.result = 32'd0; e.err = 1'b1; e.cyc = T + 2 + WD;
        sb_q.push_back(e);
      end
      default: begin start_at = T + 1; push_exp(T + 2 + lat); idle_at = T + 3 + lat; end
    endcase
  endtask

  task automatic sample();
    logic [N-1:0] exp_rdy;
    int w, idx;
    exp_rdy = '0;
    w = -1;
    if (cyc >= idle_at && !div_busy_i)
      for (int k = 0; k < N; k++) begin
        idx = (rr_m + k) % N;
        if (w < 0 && req_valid_i[idx] && !flush_i[idx]) w = idx;
      end
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 32'(req_ready_o), 32'(exp_rdy));
    check("busy", 32'(busy_o), 32'(cyc < idle_at));
    check("div_start", 32'(div_start_o), 32'(cyc == start_at));
    check("div_flush", 32'(div_flush_o), 32'(cyc == flush_at));
    if (cyc == start_at) begin
      check("div_valid", 32'(div_valid_o), 32'd1);
      check("div_funct3", 32'(div_funct3_o), 32'(acc_f3));
      check("div_rs1", div_rs1_o, acc_a);
      check("div_rs2", div_rs2_o, acc_b);
      check("div_rd", 32'(div_rd_o), 32'(acc_rd));
    end
    if (div_start_o && div_valid_o) begin
      st_res = ref_div(div_funct3_o, div_rs1_o, div_rs2_o);
      st_rd  = div_rd_o;
      st_act = 1'b1;
      st_cnt = st_hang ? 1000000 : st_lat;
    end
    if (div_flush_o) st_act = 1'b0;
    if (w >= 0) accept(w);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    reset = rst_drv;
    div_ready_i = 1'b0;
    if (st_act) begin
      st_cnt--;
      if (st_cnt == 0) begin
        div_ready_i = 1'b1; div_result_i = st_res; div_rd_i = st_rd; st_act = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]         = pend_v[i];
      req_funct3_i[i*3 +: 3] = pend_f3[i];
      req_rs1_i[i*32 +: 32]  = pend_a[i];
      req_rs2_i[i*32 +: 32]  = pend_b[i];
      req_rd_i[i*5 +: 5]     = pend_rd[i];
    end
    flush_i = '0;
    if (!quiet)
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 19) == 0 && !(cyc < idle_at && i == owner_m)) flush_i[i] = 1'b1;
    if (cyc == fl_own_at) flush_i[owner_m] = 1'b1;
    div_busy_i = !quiet && ($urandom_range(0, 9) == 0);
    if (!quiet)
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(0, 3) == 0) gen_req(i);
    @(negedge clk);
    if (rst_drv) begin
      rr_m = 0; idle_at = cyc + 1; start_at = -1; flush_at = -1; fl_own_at = -1;
      sb_q.delete();
      st_act = 1'b0;
      for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    end else begin
      sample();
    end
  endtask

  task automatic drain();
    int guard;
    logic any;
    guard = 0;
    any = 1'b1;
    while (any && guard < 400) begin
      any = (cyc < idle_at) || (sb_q.size() > 0);
      for (int i = 0; i < N; i++) if (pend_v[i]) any = 1'b1;
      if (any) begin step(); guard++; end
    end
    check("drain_timeout", 32'(guard >= 400), 32'd0);
  endtask

  task automatic check_zero();
    check("z_resp_valid", 32'(resp_valid_o), 32'd0);
    check("z_resp_rd", 32'(resp_rd_o), 32'd0);
    check("z_resp_result", resp_result_o, 32'd0);
    check("z_resp_err", 32'(resp_err_o), 32'd0);
    check("z_div_valid", 32'(div_valid_o), 32'd0);
    check("z_div_funct3", 32'(div_funct3_o), 32'd0);
    check("z_div_rs1", div_rs1_o, 32'd0);
    check("z_div_rs2", div_rs2_o, 32'd0);
    check("z_div_rd", 32'(div_rd_o), 32'd0);
  endtask

  // response monitor
  initial begin
    exp_t e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (!rst_drv) begin
        if (resp_valid_o != '0) begin
          if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL resp_unexpected cyc=%0d actual=%b required=none", cyc, resp_valid_o);
          end else begin
            e = sb_q.pop_front();
            oh = '0;
            oh[e.owner] = 1'b1;
            check("resp_valid", 32'(resp_valid_o), 32'(oh));
            check("resp_rd", 32'(resp_rd_o), 32'(e.rd));
            check("resp_result", resp_result_o, e.result);
            check("resp_err", 32'(resp_err_o), 32'(e.err));
            check("resp_cycle", 32'(cyc), 32'(e.cyc));
          end
        end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
          e = sb_q.pop_front();
          n_vec++; n_err++;
          $display("FAIL resp_missing cyc=%0d actual=none required_cyc=%0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0; pend_f3[i] = '0; pend_a[i] = '0; pend_b[i] = '0; pend_rd[i] = '0;
    end
    rst_drv = 1'b1;
    step(); step();
    rst_drv = 1'b0;
    step();
    check_zero();

    // DIV -40/8 -> rd10
    set_req(0, 3'd4, 32'hFFFF_FFD8, 32'd8, 5'd10);
    dir_mode = 0; dir_lat = 3;
    drain();

    // two rounds of simultaneous requests
    for (int r = 0; r < 2; r++) begin
      set_req(0, 3'd5, 32'd100, 32'd7, 5'd3);
      set_req(1, 3'd7, 32'd199, 32'd197, 5'd4);
      drain();
    end

    // REM -40%6 flushed in WAIT, then served normally
    set_req(1, 3'd6, 32'hFFFF_FFD8, 32'd6, 5'd12);
    dir_mode = 2; dir_lat = 4; dir_k = 1;
    drain();
    set_req(1, 3'd6, 32'hFFFF_FFD8, 32'd6, 5'd12);
    drain();

    // divider never answers: watchdog abort
    set_req(0, 3'd4, 32'd77, 32'd5, 5'd9);
    dir_mode = 4;
    drain();

    // DIVU 123/0
    set_req(1, 3'd5, 32'd123, 32'd0, 5'd21);
    dir_mode = 0; dir_lat = 2;
    drain();

    quiet = 1'b0;
    repeat (3000) step();
    quiet = 1'b1;
    drain();

    // reset in the middle of WAIT, rr pointer left at 1 beforehand
    set_req(0, 3'd5, 32'd5, 32'd3, 5'd7);
    dir_mode = 4;
    repeat (10) step();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    step();
    check_zero();
    set_req(0, 3'd6, 32'd17, 32'd5, 5'd1);
    set_req(1, 3'd4, 32'd17, 32'd5, 5'd2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
